// File: rtl/dbus_bridge_if.sv
// Bundle of CPU data-port and shared slave-bus signals for dbus_bridge.
// The bridge uses the slave view; the CPU plus slave models use the master view.
interface dbus_bridge_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 2
);
  localparam int BE_W = DATA_W / 8;

  logic                      cpu_req;
  logic [BE_W-1:0]           cpu_we;
  logic [ADDR_W-1:0]         cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic                      cpu_stall;
  logic                      cpu_rvalid;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_err;
  logic [NUM_SLV-1:0]        s_ce;
  logic [BE_W-1:0]           s_we;
  logic [ADDR_W-1:0]         s_addr;
  logic [DATA_W-1:0]         s_wdata;
  logic [NUM_SLV*DATA_W-1:0] s_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, s_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata, cpu_err, s_ce, s_we, s_addr, s_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, s_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata, cpu_err, s_ce, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/dbus_bridge.sv
// Data-bus bridge: decodes CPU requests onto NUM_SLV fixed-latency slaves,
// strobes the selected slave for one cycle and returns a one-cycle response.
module dbus_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h1FD0_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFC_0000},
  parameter logic [NUM_SLV*4-1:0]      SLV_LAT  = {4'd3, 4'd1}
) (
  input  logic          cpu_clk,
  input  logic          reset,
  dbus_bridge_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {IDLE, STRB, WAIT, RESP} state_t;

  state_t             state_reg;
  logic [3:0]         cnt_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [BE_W-1:0]    we_reg;
  logic               stall_reg;
  logic               rvalid_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic               err_reg;
  logic [NUM_SLV-1:0] s_ce_reg;
  logic [BE_W-1:0]    s_we_reg;
  logic [ADDR_W-1:0]  s_addr_reg;
  logic [DATA_W-1:0]  s_wdata_reg;

  logic [NUM_SLV-1:0] match;
  logic [DATA_W-1:0]  rdata_arr [NUM_SLV];
  logic [3:0]         lat_m1 [NUM_SLV];
  logic [IDX_W-1:0]   hit_idx;
  logic               hit;
  logic               accept;

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      localparam logic [3:0] LAT = SLV_LAT[gi*4 +: 4];
      assign match[gi]     = (bus.cpu_addr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
      assign rdata_arr[gi] = bus.s_rdata[gi*DATA_W +: DATA_W];
      // A latency of zero still needs one WAIT cycle to sample the slave.
      assign lat_m1[gi]    = (LAT == 4'd0) ? 4'd0 : LAT - 4'd1;
    end
  endgenerate

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    hit_idx = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if (match[k]) hit_idx = IDX_W'(k);
    end
  end

  assign hit    = |match;
  assign accept = bus.cpu_req && (state_reg == IDLE || state_reg == RESP);

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      we_reg      <= '0;
      stall_reg   <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      s_ce_reg    <= '0;
      s_we_reg    <= '0;
      s_addr_reg  <= '0;
      s_wdata_reg <= '0;
    end else begin
      stall_reg  <= 1'b0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      s_ce_reg   <= '0;
      s_we_reg   <= '0;
      case (state_reg)
        IDLE, RESP: begin
          if (accept) begin
            we_reg  <= bus.cpu_we;
            idx_reg <= hit_idx;
            if (hit) begin
              s_addr_reg  <= bus.cpu_addr;
              s_wdata_reg <= bus.cpu_wdata;
              s_ce_reg    <= NUM_SLV'(1) << hit_idx;
              s_we_reg    <= bus.cpu_we;
              stall_reg   <= 1'b1;
              state_reg   <= STRB;
            end else begin
              rvalid_reg <= 1'b1;
              err_reg    <= 1'b1;
              state_reg  <= RESP;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        STRB: begin
          if (we_reg != '0) begin
            rvalid_reg <= 1'b1;
            state_reg  <= RESP;
          end else begin
            cnt_reg   <= lat_m1[idx_reg];
            stall_reg <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            rdata_reg  <= rdata_arr[idx_reg];
            rvalid_reg <= 1'b1;
            state_reg  <= RESP;
          end else begin
            cnt_reg   <= cnt_reg - 4'd1;
            stall_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cpu_stall  = stall_reg;
  assign bus.cpu_rvalid = rvalid_reg;
  assign bus.cpu_rdata  = rdata_reg;
  assign bus.cpu_err    = err_reg;
  assign bus.s_ce       = s_ce_reg;
  assign bus.s_we       = s_we_reg;
  assign bus.s_addr     = s_addr_reg;
  assign bus.s_wdata    = s_wdata_reg;
endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge with latency-accurate slave read models
// that present valid data only in the cycle the bridge should sample.
module tb_dbus_bridge;
  logic cpu_clk;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] data0, data1;
  int          age0, age1;

  dbus_bridge_if #(.DATA_W(32), .ADDR_W(32), .NUM_SLV(2)) bus ();

  dbus_bridge dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // age_k counts cycles since slave k was strobed; data is valid when age == L_k.
  always @(posedge cpu_clk) begin
    age0 <= bus.s_ce[0] ? 1 : ((age0 < 100) ? age0 + 1 : age0);
    age1 <= bus.s_ce[1] ? 1 : ((age1 < 100) ? age1 + 1 : age1);
  end
  assign bus.s_rdata = {(age1 == 3) ? data1 : 32'hBAD1_BAD1,
                        (age0 == 1) ? data0 : 32'hBAD0_BAD0};

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    $display("check %-18s got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_bus"}, {bus.cpu_stall, bus.cpu_rvalid, bus.cpu_err, bus.s_ce, bus.s_we},
        64'h0);
    chk({tag, "_data"}, {bus.cpu_rdata, bus.s_addr}, 64'h0);
    chk({tag, "_wdata"}, {32'h0, bus.s_wdata}, 64'h0);
  endtask

  initial begin
    int stall_cnt, rv_at, rv_cnt, ce_cnt, first_ce, last_ce, ce_bad;
    logic [31:0] rd;
    logic [31:0] wd [4];
    logic [3:0]  wb [4];

    age0 = 100; age1 = 100;
    data0 = 32'hDEAD_BEEF; data1 = 32'hA5A5_0001;
    bus.cpu_req = 1'b0; bus.cpu_we = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    reset = 1'b1;
    tick(); tick();
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Read slave0 (L=1)
    bus.cpu_req = 1'b1; bus.cpu_we = 4'b0000; bus.cpu_addr = 32'h0000_0010;
    tick();
    bus.cpu_req = 1'b0;
    chk("rd0_ce", bus.s_ce, 2'b01);
    chk("rd0_addr", bus.s_addr, 32'h0000_0010);
    tick();
    chk("rd0_ce_off", {bus.s_ce, bus.cpu_rvalid}, 3'b000);
    tick();
    chk("rd0_resp", {bus.cpu_rvalid, bus.cpu_err, bus.cpu_rdata}, {2'b10, 32'hDEAD_BEEF});
    tick();
    chk("rd0_after", {bus.cpu_rvalid, bus.cpu_rdata}, 33'h0);

    // Write slave1 partial word
    bus.cpu_req = 1'b1; bus.cpu_we = 4'b0011; bus.cpu_addr = 32'h1FD0_F000;
    bus.cpu_wdata = 32'h1234_5678;
    tick();
    bus.cpu_req = 1'b0;
    chk("wr1_strobe", {bus.s_ce, bus.s_we, bus.s_wdata}, {2'b10, 4'b0011, 32'h1234_5678});
    chk("wr1_addr", bus.s_addr, 32'h1FD0_F000);
    tick();
    chk("wr1_resp", {bus.cpu_rvalid, bus.cpu_err, bus.cpu_rdata, bus.s_ce, bus.s_we},
        {2'b10, 32'h0, 2'b00, 4'b0000});
    chk("wr1_hold", bus.s_wdata, 32'h1234_5678);
    tick();
    chk("wr1_after", bus.cpu_rvalid, 1'b0);

    // Read slave1 (L=3): stall 4 cycles, response at accept+5
    bus.cpu_req = 1'b1; bus.cpu_we = 4'b0000; bus.cpu_addr = 32'h1FD0_0004;
    stall_cnt = 0; rv_at = -1; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) bus.cpu_req = 1'b0;
      if (bus.cpu_stall) stall_cnt++;
      if (bus.cpu_rvalid && rv_at < 0) begin rv_at = i; rd = bus.cpu_rdata; end
    end
    chk("rd1_stall", stall_cnt, 4);
    chk("rd1_latency", rv_at, 5);
    chk("rd1_data", rd, 32'hA5A5_0001);

    // Unmapped read
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8000_0000;
    tick();
    bus.cpu_req = 1'b0;
    chk("unm_resp", {bus.cpu_rvalid, bus.cpu_err, bus.cpu_rdata, bus.s_ce, bus.cpu_stall},
        {2'b11, 32'h0, 2'b00, 1'b0});
    tick();
    chk("unm_after", {bus.cpu_rvalid, bus.cpu_err, bus.s_ce}, 4'b0000);

    // Back-to-back writes to slave0 with cpu_req held high
    wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0001; wd[2] = 32'h3333_0002; wd[3] = 32'h4444_0003;
    wb[0] = 4'b1111; wb[1] = 4'b0001; wb[2] = 4'b1100; wb[3] = 4'b1000;
    ce_cnt = 0; rv_cnt = 0; first_ce = -1; last_ce = -1; ce_bad = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = wb[0]; bus.cpu_addr = 32'h0000_0100; bus.cpu_wdata = wd[0];
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (bus.cpu_rvalid) rv_cnt++;
      if (bus.s_ce != 2'b00) begin
        if (bus.s_ce != 2'b01 || ce_cnt > 3) ce_bad++;
        else if (bus.s_wdata !== wd[ce_cnt] || bus.s_we !== wb[ce_cnt] ||
                 bus.s_addr !== 32'h100 + 32'(4 * ce_cnt)) ce_bad++;
        if (first_ce < 0) first_ce = i;
        last_ce = i;
        ce_cnt++;
        if (ce_cnt < 4) begin
          bus.cpu_we = wb[ce_cnt]; bus.cpu_wdata = wd[ce_cnt];
          bus.cpu_addr = 32'h100 + 32'(4 * ce_cnt);
        end else begin
          bus.cpu_req = 1'b0;
        end
      end
    end
    chk("b2b_strobes", ce_cnt, 4);
    chk("b2b_rvalids", rv_cnt, 4);
    chk("b2b_spacing", last_ce - first_ce, 6);
    chk("b2b_content", ce_bad, 0);

    // Reset during WAIT of a slave1 read
    bus.cpu_req = 1'b1; bus.cpu_we = 4'b0000; bus.cpu_addr = 32'h1FD0_0004;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    chk("rst_in_wait", bus.cpu_stall, 1'b1);
    reset = 1'b1;
    tick();
    chk_idle_outputs("rst_abort");
    reset = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.cpu_rvalid || bus.s_ce != 2'b00) rv_cnt++;
    end
    chk("rst_no_replay", rv_cnt, 0);

    data1 = 32'h0BAD_CAFE;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h1FD0_0008;
    rv_at = -1; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) bus.cpu_req = 1'b0;
      if (bus.cpu_rvalid && rv_at < 0) begin rv_at = i; rd = bus.cpu_rdata; end
    end
    chk("post_rst_lat", rv_at, 5);
    chk("post_rst_data", rd, 32'h0BAD_CAFE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dbus_bridge.md
# dbus_bridge

Parametrised data-bus bridge between the MiniMIPS32 data port and `NUM_SLV` memory-mapped slaves, such as `data_ram` and peripheral blocks. It sits in `soc` in place of the direct CPU-to-`data_ram` wiring. The bridge:
- decodes each CPU data request by base/mask region;
- issues a single-cycle strobe to the selected slave;
- waits that slave's fixed read latency and returns the result with a valid pulse;
- stalls the CPU while a transfer is outstanding;
- flags accesses to unmapped addresses.

## Interface
Parameters:
- `DATA_W`, 32, data width; `BE_W = DATA_W/8` byte enables.
- `ADDR_W`, 32, address width.
- `NUM_SLV`, 2, number of slave ports, 1..8.
- `SLV_BASE`, {32'h1FD0_0000, 32'h0000_0000}, packed `NUM_SLV*ADDR_W`; slice k is the base of slave k.
- `SLV_MASK`, {32'hFFFF_0000, 32'hFFFC_0000}, packed `NUM_SLV*ADDR_W`; slave k matches when `(addr & mask_k) == base_k`.
- `SLV_LAT`, {4'd3, 4'd1}, packed `NUM_SLV*4`; read latency L_k of slave k in cycles. A value of 0 is treated as 1.

Ports (one clock; reset is synchronous and active-high):
- `cpu_clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request; held until accepted.
- `cpu_we` in BE_W: byte write enables; all-zero means read.
- `cpu_addr` in ADDR_W: byte address.
- `cpu_wdata` in DATA_W: write data.
- `cpu_stall` out 1: the bridge cannot accept a request this cycle.
- `cpu_rvalid` out 1: one-cycle response pulse, for reads and writes.
- `cpu_rdata` out DATA_W: read data; valid only while `cpu_rvalid` is high.
- `cpu_err` out 1: qualifies `cpu_rvalid`; the address was unmapped.
- `s_ce` out NUM_SLV: one-hot slave strobe.
- `s_we` out BE_W: byte enables, shared by all slaves.
- `s_addr` out ADDR_W: registered address, shared.
- `s_wdata` out DATA_W: registered write data, shared.
- `s_rdata` in NUM_SLV*DATA_W: slice k is the read data from slave k.

## Operation
- FSM states: IDLE, STRB, WAIT, RESP.
- Acceptance:
  - A request is accepted when `cpu_req`=1 and the state is IDLE or RESP, so back-to-back requests are allowed.
  - `cpu_stall` = 1 in STRB and WAIT, 0 otherwise.
- On acceptance:
  - Latch address, write data, byte enables and the decoded slave index.
  - Decode priority is lowest index wins.
- Decode result:
  - Match → STRB.
  - No match → RESP with `cpu_err`=1, `cpu_rdata`=0, and no slave strobe.
- STRB (one cycle):
  - `s_ce[k]`=1 and `s_we`/`s_addr`/`s_wdata` are driven from the latches.
  - Write → RESP.
  - Read → WAIT, with the counter loaded to L_k−1.
- WAIT:
  - Counter decrements every cycle.
  - In the cycle where the counter is 0, capture `s_rdata[k]` into `cpu_rdata` and go to RESP.
- RESP (one cycle):
  - `cpu_rvalid`=1.
  - `cpu_err` is set only for unmapped accesses.
  - Writes return `cpu_rdata`=0.
  - Next state is IDLE, or the accept path if `cpu_req`=1.
- Outside STRB:
  - `s_ce` is all-zero and `s_we` is 0.
  - `s_addr` and `s_wdata` hold their last values.
- `cpu_rdata`, `cpu_err` and `cpu_rvalid` are zero outside RESP.
- Partial-word writes pass `cpu_we` unchanged. The bridge does no byte lane shifting; that is the CPU's job.

## Timing
Request accepted at the clock edge ending cycle T:
- Read, mapped:
  - `s_ce` in T+1.
  - Sample `s_rdata` in cycle T+1+L.
  - `cpu_rvalid` in T+2+L, so latency is L+2.
- Write, mapped: `s_ce`/`s_we` in T+1 and `cpu_rvalid` in T+2.
- Unmapped: `cpu_rvalid`+`cpu_err` in T+1.
- Back-to-back: acceptance in a RESP cycle puts the next STRB in the following cycle, giving a sustained write throughput of 1 per 2 cycles.
- Reset value of every output is 0, with state IDLE and counter 0.
- Reset asserted mid-transfer:
  - Abort at the next edge.
  - `s_ce` drops and no `cpu_rvalid` is issued.
  - An aborted request is never replayed.
- `cpu_req` while `cpu_stall`=1 is ignored. The CPU must hold it.
- An address matching two regions goes to the lower index only.

## Test plan
- Read from slave0 (L=1), addr 0x0000_0010, with the RAM model returning 0xDEAD_BEEF:
  - `s_ce`=2'b01 for exactly 1 cycle.
  - `cpu_rvalid` 3 cycles after accept, `cpu_rdata`=0xDEAD_BEEF, `cpu_err`=0.
- Write to slave1 (L=3), addr 0x1FD0_F000, `cpu_we`=4'b0011, wdata 0x1234_5678:
  - `s_ce`=2'b10 with `s_we`=4'b0011 and `s_wdata`=0x1234_5678 for 1 cycle.
  - `cpu_rvalid` 2 cycles after accept, `cpu_rdata`=0.
- Read slave1 at 0x1FD0_0004 with model data 0xA5A5_0001:
  - `cpu_stall` high for 4 cycles.
  - `cpu_rvalid` 5 cycles after accept with 0xA5A5_0001.
- Read at unmapped address 0x8000_0000:
  - `s_ce` never asserted.
  - Next cycle `cpu_rvalid`=1, `cpu_err`=1, `cpu_rdata`=0.
- Back-to-back: 4 writes to slave0 with `cpu_req` held high:
  - `s_ce` pulses every 2nd cycle.
  - 4 `cpu_rvalid` pulses, no request lost.
- Reset asserted during WAIT of a slave1 read:
  - All outputs 0 on the next cycle.
  - No `cpu_rvalid`.
  - A subsequent read completes normally with L+2 latency.
